// File: rtl/rv32_barrel_mvu_jobctl_pkg.sv
// Shared types and constants for the barrel-core MVU job controller.
//   mvu_job_state_t   per-hart job FSM state (also the STATUS[1:0] encoding)
//   CSR_OP_*          CSR operation codes presented by the CSR stage
//   MVU_JOB_*_OFS     CMD/STATUS offsets, relative to NUM_REGS
//   STAT_*            STATUS register bit positions
package rv32_barrel_mvu_jobctl_pkg;

    typedef enum logic [1:0] {
        MVU_JOB_IDLE    = 2'd0,
        MVU_JOB_PENDING = 2'd1,
        MVU_JOB_RUNNING = 2'd2,
        MVU_JOB_DONE    = 2'd3
    } mvu_job_state_t;

    localparam logic [2:0] CSR_OP_NONE  = 3'd0;
    localparam logic [2:0] CSR_OP_READ  = 3'd1;
    localparam logic [2:0] CSR_OP_WRITE = 3'd2;
    localparam logic [2:0] CSR_OP_SET   = 3'd3;
    localparam logic [2:0] CSR_OP_CLEAR = 3'd4;

    // CMD and STATUS follow the NUM_REGS config words.
    localparam int unsigned MVU_JOB_CMD_OFS  = 0;
    localparam int unsigned MVU_JOB_STAT_OFS = 1;

    localparam int unsigned STAT_STATE_LSB   = 0;
    localparam int unsigned STAT_IRQ_BIT     = 2;
    localparam int unsigned STAT_RESTART_BIT = 3;

    function automatic logic csr_is_access(input logic [2:0] op);
        return (op == CSR_OP_READ) || (op == CSR_OP_WRITE) ||
               (op == CSR_OP_SET)  || (op == CSR_OP_CLEAR);
    endfunction

endpackage

// File: rtl/rv32_barrel_mvu_jobctl_fsm.sv
// Per-hart MVU job FSM: start/ready/done handshake, 1-deep restart queue,
// sticky completion interrupt.
//   clk, rst_n     clock, synchronous active-low reset
//   start_req_i    legal CMD write with bit 0 set, this hart
//   irq_clr_i      legal STATUS clear of irq_pend, this hart
//   ready_i        MVU can accept a job
//   done_i         1-cycle job-complete pulse from MVU
//   state_o        current state (mvu_job_state_t encoding)
//   restart_o      restart queued
//   irq_o          sticky completion interrupt
//   start_o        registered 1-cycle start pulse to MVU
//   accept_o       PENDING and ready: active config loads on this edge
//   busy_o         PENDING or RUNNING
module rv32_mvu_job_fsm
    import rv32_barrel_mvu_jobctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_req_i,
    input  logic       irq_clr_i,
    input  logic       ready_i,
    input  logic       done_i,
    output logic [1:0] state_o,
    output logic       restart_o,
    output logic       irq_o,
    output logic       start_o,
    output logic       accept_o,
    output logic       busy_o
);

    mvu_job_state_t state_q;
    logic           restart_q;
    logic           irq_q;
    logic           start_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MVU_JOB_IDLE;
            restart_q <= 1'b0;
            irq_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            // Clear first so a completion in the same cycle overrides it.
            if (irq_clr_i) begin
                irq_q <= 1'b0;
            end
            case (state_q)
                MVU_JOB_IDLE, MVU_JOB_DONE: begin
                    if (start_req_i) begin
                        state_q <= MVU_JOB_PENDING;
                    end
                end
                MVU_JOB_PENDING: begin
                    if (ready_i) begin
                        state_q <= MVU_JOB_RUNNING;
                        start_q <= 1'b1;
                    end
                end
                MVU_JOB_RUNNING: begin
                    if (done_i) begin
                        irq_q <= 1'b1;
                        // A start request arriving with done counts as queued.
                        if (restart_q || start_req_i) begin
                            state_q   <= MVU_JOB_PENDING;
                            restart_q <= 1'b0;
                        end else begin
                            state_q <= MVU_JOB_DONE;
                        end
                    end else if (start_req_i) begin
                        restart_q <= 1'b1;
                    end
                end
                default: state_q <= MVU_JOB_IDLE;
            endcase
        end
    end

    assign state_o   = state_q;
    assign restart_o = restart_q;
    assign irq_o     = irq_q;
    assign start_o   = start_q;
    assign accept_o  = (state_q == MVU_JOB_PENDING) && ready_i;
    assign busy_o    = (state_q == MVU_JOB_PENDING) || (state_q == MVU_JOB_RUNNING);

endmodule

// File: rtl/rv32_barrel_mvu_jobctl.sv
// Per-hart MVU CSR fan-out with double-buffered config words and job control.
//   clk, rst_n     clock, synchronous active-low reset
//   hart_id_i      hart issuing the CSR access this cycle
//   csr_addr/csr_wdata/csr_op   CSR access (op outside READ/WRITE/SET/CLEAR = none)
//   csr_rdata      combinational read data (0 on miss, no access, illegal)
//   csr_hit        address inside config/CMD/STATUS window
//   csr_illegal    bad hart id or SET/CLEAR to CMD; access has no effect
//   mvu_ready/mvu_done   per-MVU handshake inputs
//   mvu_start      per-MVU 1-cycle start pulse
//   mvu_cfg        active config, word r of hart h at [(h*NUM_REGS+r)*32 +: 32]
//   mvu_busy/mvu_irq     per-hart job busy / sticky completion interrupt
module rv32_barrel_mvu_jobctl
    import rv32_barrel_mvu_jobctl_pkg::*;
#(
    parameter int unsigned NUM_HARTS      = 8,
    parameter int unsigned NUM_REGS       = 31,
    parameter logic [11:0] BASE_ADDR      = 12'hF20,
    // One extra code point so an out-of-range hart id is representable.
    parameter int unsigned HART_CNT_WIDTH = $clog2(NUM_HARTS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [HART_CNT_WIDTH-1:0]       hart_id_i,
    input  logic [11:0]                     csr_addr,
    input  logic [31:0]                     csr_wdata,
    input  logic [2:0]                      csr_op,
    output logic [31:0]                     csr_rdata,
    output logic                            csr_hit,
    output logic                            csr_illegal,
    input  logic [NUM_HARTS-1:0]            mvu_ready,
    input  logic [NUM_HARTS-1:0]            mvu_done,
    output logic [NUM_HARTS-1:0]            mvu_start,
    output logic [NUM_HARTS*NUM_REGS*32-1:0] mvu_cfg,
    output logic [NUM_HARTS-1:0]            mvu_busy,
    output logic [NUM_HARTS-1:0]            mvu_irq
);

    localparam logic [11:0] CMD_OFS  = 12'(NUM_REGS + MVU_JOB_CMD_OFS);
    localparam logic [11:0] STAT_OFS = 12'(NUM_REGS + MVU_JOB_STAT_OFS);
    localparam logic [HART_CNT_WIDTH-1:0] HART_LIMIT = HART_CNT_WIDTH'(NUM_HARTS);

    logic [31:0] shadow_q [NUM_HARTS][NUM_REGS];
    logic [31:0] active_q [NUM_HARTS][NUM_REGS];

    logic [11:0] ofs;
    logic        is_access;
    logic        is_cmd;
    logic        is_stat;
    logic        is_cfg;
    logic        illegal;
    logic        legal;
    logic        shadow_we;
    logic [31:0] shadow_d;
    logic [31:0] rd_shadow;
    logic [31:0] rd_status;

    logic [NUM_HARTS-1:0] start_req;
    logic [NUM_HARTS-1:0] irq_clr;
    logic [NUM_HARTS-1:0] accept;
    logic [NUM_HARTS-1:0] restart;
    logic [1:0]           state [NUM_HARTS];

    // Address decode
    assign ofs       = csr_addr - BASE_ADDR;
    assign csr_hit   = (csr_addr >= BASE_ADDR) && (ofs <= STAT_OFS);
    assign is_access = csr_is_access(csr_op);
    assign is_cmd    = (ofs == CMD_OFS);
    assign is_stat   = (ofs == STAT_OFS);
    assign is_cfg    = (ofs < CMD_OFS);
    assign illegal   = csr_hit && is_access &&
                       ((hart_id_i >= HART_LIMIT) ||
                        (is_cmd && ((csr_op == CSR_OP_SET) || (csr_op == CSR_OP_CLEAR))));
    assign legal     = csr_hit && is_access && !illegal;
    assign shadow_we = legal && is_cfg && (csr_op != CSR_OP_READ);
    assign csr_illegal = rst_n && illegal;

    // Selected hart's shadow word and STATUS
    always_comb begin
        rd_shadow = '0;
        rd_status = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (hart_id_i == HART_CNT_WIDTH'(h)) begin
                rd_status[STAT_STATE_LSB +: 2] = state[h];
                rd_status[STAT_IRQ_BIT]        = mvu_irq[h];
                rd_status[STAT_RESTART_BIT]    = restart[h];
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (ofs == 12'(r)) begin
                        rd_shadow = shadow_q[h][r];
                    end
                end
            end
        end
    end

    always_comb begin
        case (csr_op)
            CSR_OP_SET:   shadow_d = rd_shadow | csr_wdata;
            CSR_OP_CLEAR: shadow_d = rd_shadow & ~csr_wdata;
            default:      shadow_d = csr_wdata;
        endcase
    end

    always_comb begin
        csr_rdata = '0;
        if (legal) begin
            if (is_cfg) begin
                csr_rdata = rd_shadow;
            end else if (is_stat) begin
                csr_rdata = rd_status;
            end
        end
    end

    always_comb begin
        start_req = '0;
        irq_clr   = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (legal && (hart_id_i == HART_CNT_WIDTH'(h))) begin
                start_req[h] = is_cmd && (csr_op == CSR_OP_WRITE) && csr_wdata[0];
                irq_clr[h]   = is_stat && ((csr_op == CSR_OP_WRITE) || (csr_op == CSR_OP_SET)) &&
                               csr_wdata[STAT_IRQ_BIT];
            end
        end
    end

    // Active copies the pre-edge shadow, so a shadow write on the accept
    // edge lands in shadow only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    shadow_q[h][r] <= '0;
                    active_q[h][r] <= '0;
                end
            end
        end else begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (accept[h]) begin
                        active_q[h][r] <= shadow_q[h][r];
                    end
                    if (shadow_we && (hart_id_i == HART_CNT_WIDTH'(h)) && (ofs == 12'(r))) begin
                        shadow_q[h][r] <= shadow_d;
                    end
                end
            end
        end
    end

    always_comb begin
        mvu_cfg = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mvu_cfg[(h*NUM_REGS+r)*32 +: 32] = active_q[h][r];
            end
        end
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        rv32_mvu_job_fsm u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_req_i (start_req[g]),
            .irq_clr_i   (irq_clr[g]),
            .ready_i     (mvu_ready[g]),
            .done_i      (mvu_done[g]),
            .state_o     (state[g]),
            .restart_o   (restart[g]),
            .irq_o       (mvu_irq[g]),
            .start_o     (mvu_start[g]),
            .accept_o    (accept[g]),
            .busy_o      (mvu_busy[g])
        );
    end

endmodule

// File: tb/tb_rv32_barrel_mvu_jobctl.sv
module tb_rv32_barrel_mvu_jobctl;
    import rv32_barrel_mvu_jobctl_pkg::*;

    localparam int NH = 8;
    localparam int NR = 31;
    localparam logic [11:0] CFG0 = 12'hF20;
    localparam logic [11:0] CMD  = 12'hF3F;
    localparam logic [11:0] STAT = 12'hF40;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [3:0]            hart_id_i = '0;
    logic [11:0]           csr_addr = '0;
    logic [31:0]           csr_wdata = '0;
    logic [2:0]            csr_op = CSR_OP_NONE;
    logic [31:0]           csr_rdata;
    logic                  csr_hit;
    logic                  csr_illegal;
    logic [NH-1:0]         mvu_ready = '0;
    logic [NH-1:0]         mvu_done = '0;
    logic [NH-1:0]         mvu_start;
    logic [NH*NR*32-1:0]   mvu_cfg;
    logic [NH-1:0]         mvu_busy;
    logic [NH-1:0]         mvu_irq;

    typedef struct {
        int          hart;
        int          cyc;
        logic [31:0] cfg0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rv32_barrel_mvu_jobctl #(
        .NUM_HARTS (NH),
        .NUM_REGS  (NR),
        .BASE_ADDR (12'hF20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hart_id_i   (hart_id_i),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_op      (csr_op),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .csr_illegal (csr_illegal),
        .mvu_ready   (mvu_ready),
        .mvu_done    (mvu_done),
        .mvu_start   (mvu_start),
        .mvu_cfg     (mvu_cfg),
        .mvu_busy    (mvu_busy),
        .mvu_irq     (mvu_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] cfg_word(input int h, input int r);
        return mvu_cfg[(h*NR+r)*32 +: 32];
    endfunction

    // Scoreboard: every start pulse must match the oldest expected start.
    always @(negedge clk) begin
        for (int h = 0; h < NH; h++) begin
            if (mvu_start[h]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: hart %0d pulsed at cycle %0d, none expected", h, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (h !== e.hart || cyc !== e.cyc || cfg_word(h, 0) !== e.cfg0) begin
                        errors++;
                        $display("FAIL start_event: got hart %0d cyc %0d cfg0 %h, expected hart %0d cyc %0d cfg0 %h",
                                 h, cyc, cfg_word(h, 0), e.hart, e.cyc, e.cfg0);
                    end
                end
            end
        end
    end

    task automatic csr(input int h, input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd);
        hart_id_i = 4'(h);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        csr_op = CSR_OP_NONE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        csr(8, CFG0, CSR_OP_READ, 0);
        #1;
        checks++;
        if ({mvu_start, mvu_busy, mvu_irq} !== '0 || csr_illegal !== 1'b0 || mvu_cfg !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start %b busy %b irq %b illegal %b cfg_nonzero %b, expected all 0",
                     mvu_start, mvu_busy, mvu_irq, csr_illegal, mvu_cfg != '0);
        end
        rst_n = 1'b1;
        step();
        csr(0, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 00000000", csr_rdata);
        end
    endtask

    task automatic test_start();
        mvu_ready = 8'b0000_0100;
        csr(2, CFG0, CSR_OP_WRITE, 32'hA5A5_0001);
        step();
        csr(2, CMD, CSR_OP_WRITE, 32'h1);
        sb.push_back('{hart: 2, cyc: cyc + 2, cfg0: 32'hA5A5_0001});
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h1 || mvu_busy !== 8'b0000_0100) begin
            errors++;
            $display("FAIL start_pending: status %h busy %b, expected 00000001 00000100", csr_rdata, mvu_busy);
        end
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h2 || cfg_word(2, 0) !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL start_running: status %h cfg0 %h, expected 00000002 a5a50001", csr_rdata, cfg_word(2, 0));
        end
        checks++;
        begin
            logic others_zero;
            others_zero = 1'b1;
            for (int h = 0; h < NH; h++)
                for (int r = 0; r < NR; r++)
                    if (h != 2 && cfg_word(h, r) !== 32'h0) others_zero = 1'b0;
            if (!others_zero || mvu_irq !== '0) begin
                errors++;
                $display("FAIL start_isolation: other harts cfg zero %b irq %b, expected 1 00000000", others_zero, mvu_irq);
            end
        end
        csr(2, CFG0, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'hA5A5_0001 || csr_hit !== 1'b1) begin
            errors++;
            $display("FAIL shadow_read: got %h hit %b expected a5a50001 1", csr_rdata, csr_hit);
        end
        step();
    endtask

    task automatic test_restart();
        int d;
        csr(2, CFG0, CSR_OP_WRITE, 32'h2);
        step();
        csr(2, CMD, CSR_OP_WRITE, 32'h1);
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'hA || cfg_word(2, 0) !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL restart_queued: status %h cfg0 %h, expected 0000000a a5a50001", csr_rdata, cfg_word(2, 0));
        end
        mvu_done = 8'b0000_0100;
        d = cyc;
        sb.push_back('{hart: 2, cyc: d + 2, cfg0: 32'h2});
        step();
        mvu_done = '0;
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h5 || cfg_word(2, 0) !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL restart_pending: status %h cfg0 %h, expected 00000005 a5a50001", csr_rdata, cfg_word(2, 0));
        end
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h6 || cfg_word(2, 0) !== 32'h2 || mvu_irq !== 8'b0000_0100) begin
            errors++;
            $display("FAIL restart_running: status %h cfg0 %h irq %b, expected 00000006 00000002 00000100",
                     csr_rdata, cfg_word(2, 0), mvu_irq);
        end
    endtask

    task automatic test_irq_clear();
        mvu_done = 8'b0000_0100;
        csr(2, STAT, CSR_OP_WRITE, 32'h4);
        step();
        mvu_done = '0;
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (mvu_irq[2] !== 1'b1 || csr_rdata !== 32'h7) begin
            errors++;
            $display("FAIL irq_set_wins: irq %b status %h, expected 1 00000007", mvu_irq[2], csr_rdata);
        end
        csr(2, STAT, CSR_OP_WRITE, 32'h4);
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (mvu_irq[2] !== 1'b0 || csr_rdata !== 32'h3) begin
            errors++;
            $display("FAIL irq_clear: irq %b status %h, expected 0 00000003", mvu_irq[2], csr_rdata);
        end
    endtask

    task automatic test_ready_low();
        int bad;
        csr(5, CMD, CSR_OP_WRITE, 32'h1);
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) csr(5, CMD, CSR_OP_WRITE, 32'h1);
            #1;
            if (mvu_busy[5] !== 1'b1) bad++;
            step();
        end
        csr(5, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (bad != 0 || csr_rdata !== 32'h1) begin
            errors++;
            $display("FAIL ready_low_hold: %0d cycles not busy, status %h, expected 0 00000001", bad, csr_rdata);
        end
        mvu_ready[5] = 1'b1;
        sb.push_back('{hart: 5, cyc: cyc + 1, cfg0: 32'h0});
        step();
        step();
        csr(5, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h2) begin
            errors++;
            $display("FAIL ready_late_run: status %h expected 00000002", csr_rdata);
        end
    endtask

    task automatic test_rmw();
        csr(1, CFG0, CSR_OP_WRITE, 32'hF0);
        step();
        csr(1, CFG0, CSR_OP_SET, 32'h0F);
        step();
        csr(1, CFG0, CSR_OP_CLEAR, 32'h30);
        step();
        csr(1, CFG0, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'hCF) begin
            errors++;
            $display("FAIL shadow_rmw: got %h expected 000000cf", csr_rdata);
        end
        csr(1, 12'hF3E, CSR_OP_WRITE, 32'h1234_5678);
        step();
        csr(1, 12'hF3E, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h1234_5678 || cfg_word(1, NR - 1) !== 32'h0) begin
            errors++;
            $display("FAIL shadow_last: got %h active %h expected 12345678 00000000", csr_rdata, cfg_word(1, NR - 1));
        end
    endtask

    task automatic test_illegal();
        csr(2, CMD, CSR_OP_SET, 32'h1);
        #1;
        checks++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal_set_cmd: illegal %b rdata %h expected 1 00000000", csr_illegal, csr_rdata);
        end
        step();
        csr(2, CMD, CSR_OP_CLEAR, 32'h1);
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h3 || csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_no_effect: status %h illegal %b expected 00000003 0", csr_rdata, csr_illegal);
        end
        csr(8, CFG0, CSR_OP_WRITE, 32'hDEAD);
        #1;
        checks++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal_hart: illegal %b rdata %h expected 1 00000000", csr_illegal, csr_rdata);
        end
        step();
        csr(0, CFG0, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal_hart_write: hart0 shadow0 %h expected 00000000", csr_rdata);
        end
        csr(8, STAT, CSR_OP_NONE, 0);
        #1;
        checks++;
        if (csr_illegal !== 1'b0 || csr_hit !== 1'b1) begin
            errors++;
            $display("FAIL no_access: illegal %b hit %b expected 0 1", csr_illegal, csr_hit);
        end
        csr(2, 12'hF1F, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_hit !== 1'b0 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL hit_below: hit %b rdata %h expected 0 00000000", csr_hit, csr_rdata);
        end
        csr(2, 12'hF41, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_above: hit %b expected 0", csr_hit);
        end
        csr(2, CMD, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_hit !== 1'b1 || csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL cmd_read: hit %b illegal %b rdata %h expected 1 0 00000000", csr_hit, csr_illegal, csr_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int d;
        csr(2, CMD, CSR_OP_WRITE, 32'h1);
        sb.push_back('{hart: 2, cyc: cyc + 2, cfg0: 32'h2});
        step();
        step();
        csr(2, CMD, CSR_OP_WRITE, 32'h1);
        step();
        mvu_done = 8'b0000_0100;
        d = cyc;
        sb.push_back('{hart: 2, cyc: d + 2, cfg0: 32'h2});
        step();
        mvu_done = '0;
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h6 || mvu_irq[2] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: status %h irq %b expected 00000006 1", csr_rdata, mvu_irq[2]);
        end
        rst_n = 1'b0;
        step();
        csr(8, CMD, CSR_OP_SET, 32'h1);
        #1;
        checks++;
        if ({mvu_start, mvu_busy, mvu_irq} !== '0 || csr_illegal !== 1'b0 || mvu_cfg !== '0) begin
            errors++;
            $display("FAIL midjob_reset: start %b busy %b irq %b illegal %b cfg_nonzero %b, expected all 0",
                     mvu_start, mvu_busy, mvu_irq, csr_illegal, mvu_cfg != '0);
        end
        rst_n = 1'b1;
        step();
        csr(2, STAT, CSR_OP_READ, 0);
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_status: got %h expected 00000000", csr_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_start();
        test_restart();
        test_irq_clear();
        test_ready_low();
        test_rmw();
        test_illegal();
        test_reset_mid();
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL start_missing: %0d expected start pulses never seen", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
